// File: rtl/adaptive_fir_par.sv
// adaptive_fir_par: LMS-style adaptive FIR, one output sample per run.
// Each accepted request shifts a new sample into the delay line, updates
// every tap weight (optionally) and accumulates the a-posteriori dot product.
// LANES taps are processed per cycle through a short per-lane pipeline:
//   s1: update term (weight_adjust * x) captured
//   s2: weight written back, post-update weight captured
//   s3: weight * x product captured, then folded into the accumulator
module adaptive_fir_par #(
  parameter int TAPS  = 128,
  parameter int LANES = 2,
  parameter int DW    = 16,
  parameter int WFRAC = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] weight_adjust,
  input  logic                 adapt_en,
  input  logic                 clear_w,
  input  logic                 fir_go,
  output logic                 busy,
  output logic signed [DW-1:0] out_sample,
  output logic                 out_valid,
  output logic                 done,
  output logic                 sat_flag
);

  localparam int G  = TAPS / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
  // Two extra guard bits on top of the full-precision sum of TAPS products.
  localparam int AW = 2 * DW + $clog2(TAPS) + 2;
  // Alignment of weight_adjust*x (Q2.(2DW-2)) onto the weight grid (Q.WFRAC).
  localparam int SH = 2 * (DW - 1) - WFRAC;

  localparam logic signed [AW-1:0] MAX_V = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic signed [DW-1:0] x_q [TAPS];
  logic signed [DW-1:0] w_q [TAPS];
  logic signed [DW-1:0] wa_q;
  logic                 adapt_q;

  logic [GW-1:0] grp_q;
  logic [GW-1:0] grp1_q;
  logic          v1_q, v2_q, v3_q;

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] lane_sum;
  logic signed [AW-1:0] acc_scaled;
  logic                 out_ovf;

  logic signed [DW-1:0] out_q;
  logic                 valid_q;
  logic                 sat_q;

  logic accept, clear_now, issue, last_grp, pipe_empty, finish;

  logic [IW-1:0]          iss_idx [LANES];
  logic [IW-1:0]          upd_idx [LANES];
  logic signed [DW-1:0]   x_sel   [LANES];
  logic signed [DW-1:0]   w_cur   [LANES];
  logic signed [AW-1:0]   w_sum   [LANES];
  logic signed [DW-1:0]   w_new   [LANES];
  logic signed [2*DW-1:0] mac3    [LANES];
  logic [LANES-1:0]       w_ovf;

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
    if (v > MAX_V) begin
      sat_dw = MAX_V[DW-1:0];
    end else if (v < MIN_V) begin
      sat_dw = MIN_V[DW-1:0];
    end else begin
      sat_dw = v[DW-1:0];
    end
  endfunction

  // A start is only taken from IDLE, and a coincident clear wins over it.
  assign accept     = (state_q == S_IDLE) && fir_go && !clear_w;
  assign clear_now  = (state_q == S_IDLE) && clear_w;
  assign issue      = (state_q == S_RUN);
  assign last_grp   = (grp_q == GW'(G - 1));
  assign pipe_empty = !v1_q && !v2_q && !v3_q;
  assign finish     = (state_q == S_FINISH);

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: issue all lane groups, wait for the pipe, emit result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_RUN;
      S_RUN:    if (last_grp) state_d = S_DRAIN;
      S_DRAIN:  if (pipe_empty) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Delay line shifts once per accepted run; run parameters are frozen here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      wa_q    <= '0;
      adapt_q <= 1'b0;
    end else if (accept) begin
      for (int k = TAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
      x_q[0]  <= x_in;
      wa_q    <= weight_adjust;
      adapt_q <= adapt_en;
    end
  end

  // Group issue counter and per-stage valid flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grp_q  <= '0;
      grp1_q <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
    end else begin
      v1_q   <= issue;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      grp1_q <= grp_q;
      if (accept) begin
        grp_q <= '0;
      end else if (issue) begin
        grp_q <= grp_q + GW'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [2*DW-1:0] prod_q;
      logic signed [DW-1:0]   x1_q;
      logic signed [DW-1:0]   w2_q;
      logic signed [DW-1:0]   x2_q;
      logic signed [2*DW-1:0] mac_q;

      // Taps of a group are consecutive: k = group*LANES + lane.
      assign iss_idx[gi] = IW'(int'(grp_q) * LANES + gi);
      assign upd_idx[gi] = IW'(int'(grp1_q) * LANES + gi);
      assign x_sel[gi]   = x_q[iss_idx[gi]];
      assign w_cur[gi]   = w_q[upd_idx[gi]];

      // Floor-shifted update term added at full width, then clamped.
      assign w_sum[gi] = AW'(w_cur[gi]) + AW'(prod_q >>> SH);
      assign w_ovf[gi] = adapt_q && ((w_sum[gi] > MAX_V) || (w_sum[gi] < MIN_V));
      assign w_new[gi] = adapt_q ? sat_dw(w_sum[gi]) : w_cur[gi];
      assign mac3[gi]  = mac_q;

      // Lane pipeline: update term, post-update weight, MAC product.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          prod_q <= '0;
          x1_q   <= '0;
          w2_q   <= '0;
          x2_q   <= '0;
          mac_q  <= '0;
        end else begin
          if (adapt_q) begin
            prod_q <= wa_q * x_sel[gi];
          end else begin
            prod_q <= '0;
          end
          x1_q  <= x_sel[gi];
          w2_q  <= w_new[gi];
          x2_q  <= x1_q;
          mac_q <= w2_q * x2_q;
        end
      end
    end
  endgenerate

  // Weight bank: bulk clear from IDLE, otherwise write back the s2 result.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_now) begin
      for (int k = 0; k < TAPS; k++) w_q[k] <= '0;
    end else if (v1_q) begin
      for (int l = 0; l < LANES; l++) w_q[upd_idx[l]] <= w_new[l];
    end
  end

  // Sum of the current lane products, sign-extended to accumulator width.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + AW'(mac3[l]);
  end

  // Accumulator starts at the offset aligned to the product grid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= AW'(a_in) <<< WFRAC;
    end else if (v3_q) begin
      acc_q <= acc_q + lane_sum;
    end
  end

  assign acc_scaled = acc_q >>> WFRAC;
  assign out_ovf    = (acc_scaled > MAX_V) || (acc_scaled < MIN_V);

  // Result register, done pulse and sticky per-run saturation flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= finish;
      if (finish) begin
        out_q <= sat_dw(acc_scaled);
      end
      if (accept) begin
        sat_q <= 1'b0;
      end else if ((v1_q && |w_ovf) || (finish && out_ovf)) begin
        sat_q <= 1'b1;
      end
    end
  end

  // busy covers the done cycle, in which the FSM is already back in IDLE.
  assign busy       = (state_q != S_IDLE) || valid_q;
  assign out_sample = out_q;
  assign out_valid  = valid_q;
  assign done       = valid_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_adaptive_fir_par.sv
// Testbench for adaptive_fir_par: directed cases plus randomized runs
// compared against an arithmetic reference model of the adaptive filter.
module tb_adaptive_fir_par;

  localparam int TAPS  = 8;
  localparam int LANES = 2;
  localparam int DW    = 16;
  localparam int WFRAC = 12;
  localparam int LAT   = TAPS / LANES + 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] x_in = '0;
  logic signed [DW-1:0] a_in = '0;
  logic signed [DW-1:0] weight_adjust = '0;
  logic                 adapt_en = 1'b0;
  logic                 clear_w = 1'b0;
  logic                 fir_go = 1'b0;
  logic                 busy;
  logic signed [DW-1:0] out_sample;
  logic                 out_valid;
  logic                 done;
  logic                 sat_flag;

  int n_total = 0;
  int n_bad   = 0;
  int txn_no  = 0;

  longint mw [TAPS];
  longint mx [TAPS];

  longint obs;
  longint he [3];
  bit     hs;
  int     pulses;
  int     seen;

  adaptive_fir_par #(
    .TAPS (TAPS),
    .LANES(LANES),
    .DW   (DW),
    .WFRAC(WFRAC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x_in         (x_in),
    .a_in         (a_in),
    .weight_adjust(weight_adjust),
    .adapt_en     (adapt_en),
    .clear_w      (clear_w),
    .fir_go       (fir_go),
    .busy         (busy),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .done         (done),
    .sat_flag     (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      mw[k] = 0;
      mx[k] = 0;
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) mw[k] = 0;
  endtask

  // One run: shift history, adapt weights, a-posteriori dot product plus offset.
  task automatic model_run(input shortint xv, input shortint av, input shortint wv,
                           input bit ad, output longint eo, output bit es);
    longint acc, d, n;
    es = 1'b0;
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = longint'(xv);
    if (ad) begin
      for (int k = 0; k < TAPS; k++) begin
        d = (longint'(wv) * mx[k]) >>> (2 * (DW - 1) - WFRAC);
        n = mw[k] + d;
        if (n > 32767) begin
          n = 32767;
          es = 1'b1;
        end else if (n < -32768) begin
          n = -32768;
          es = 1'b1;
        end
        mw[k] = n;
      end
    end
    acc = longint'(av) * (longint'(1) << WFRAC);
    for (int k = 0; k < TAPS; k++) acc = acc + mw[k] * mx[k];
    eo = acc >>> WFRAC;
    if (eo > 32767) begin
      eo = 32767;
      es = 1'b1;
    end else if (eo < -32768) begin
      eo = -32768;
      es = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    fir_go  = 1'b0;
    clear_w = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Called #1 after a rising edge with the DUT idle (or in its done cycle).
  task automatic run_txn(input string tag, input shortint xv, input shortint av,
                         input shortint wv, input bit ad, input bit poke,
                         output longint got);
    longint eo;
    bit     es;
    int     lat;
    model_run(xv, av, wv, ad, eo, es);
    x_in = xv;
    a_in = av;
    weight_adjust = wv;
    adapt_en = ad;
    fir_go = 1'b1;
    @(posedge clk);
    #1 fir_go = 1'b0;
    check({tag, "_busy0"}, busy, 1);
    lat = -1;
    for (int c = 1; c <= 3 * LAT && lat < 0; c++) begin
      if (poke && c >= 2 && c <= 4) begin
        fir_go = 1'b1;
        clear_w = 1'b1;
        x_in = shortint'($urandom);
        a_in = shortint'($urandom);
        weight_adjust = shortint'($urandom);
        adapt_en = ~ad;
      end else begin
        fir_go = 1'b0;
        clear_w = 1'b0;
      end
      @(posedge clk);
      #1;
      if (out_valid) lat = c;
    end
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_out"}, out_sample, eo);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_done"}, busy, 1);
    check({tag, "_sat"}, sat_flag, es);
    got = out_sample;
    $display("txn %0d %s x=%h a=%h wa=%h ad=%0d poke=%0d lat=%0d out=%h exp=%h sat=%0d exp_sat=%0d",
             txn_no, tag, xv, av, wv, ad, poke, lat, out_sample, 16'(eo), sat_flag, es);
    txn_no++;
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, out_valid, 0);
    check({tag, "_hold"}, out_sample, eo);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic clear_weights(input bit with_go);
    clear_w = 1'b1;
    fir_go = with_go;
    @(posedge clk);
    #1;
    clear_w = 1'b0;
    fir_go = 1'b0;
    model_clear();
    check("clear_noaccept", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Idle after reset: everything quiet.
    repeat (5) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_out", out_sample, 0);

    // Offset only: zero weights pass a_in through.
    run_txn("req35", 16'sh7FFF, 16'sh1000, 16'sh0000, 1'b0, 1'b0, obs);
    check("req35_val", obs, 'h1000);

    // Single-tap adaptation from clean history.
    do_reset();
    run_txn("req36", 16'sh4000, 16'sh0000, 16'sh4000, 1'b1, 1'b0, obs);
    check("req36_val", obs, 'h1000);

    // Output saturation using the weight learned above.
    run_txn("req37", 16'sh4000, 16'sh7FFF, 16'sh0000, 1'b0, 1'b0, obs);
    check("req37_val", obs, 'h7FFF);
    check("req37_sat_held", sat_flag, 1);

    // Clear wins over a coincident start; weights really are gone afterwards.
    clear_weights(1'b1);
    run_txn("clr_run", 16'sh1111, 16'sh1234, 16'sh0000, 1'b0, 1'b0, obs);
    check("clr_val", obs, 'h1234);

    // Drive weights into saturation with repeated large positive updates.
    for (int i = 0; i < 10; i++) begin
      run_txn("climb", 16'sh7FFF, 16'sh0000, 16'sh7FFF, 1'b1, i[0], obs);
    end
    clear_weights(1'b0);

    // Randomized runs, some with ignored fir_go/clear_w/input traffic mid-run.
    for (int i = 0; i < 30; i++) begin
      run_txn("rand", shortint'($urandom), shortint'($urandom), shortint'($urandom),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), obs);
    end

    // fir_go held high: back-to-back accepts every LAT+1 cycles.
    for (int r = 0; r < 3; r++) model_run(16'sh2000, 16'sh0100, 16'sh3000, 1'b1, he[r], hs);
    x_in = 16'sh2000;
    a_in = 16'sh0100;
    weight_adjust = 16'sh3000;
    adapt_en = 1'b1;
    fir_go = 1'b1;
    @(posedge clk);
    #1;
    pulses = 0;
    for (int c = 1; c <= 3 * (LAT + 1) - 1; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        check("held_cycle", c, 10 * pulses + LAT);
        if (pulses < 3) check("held_out", out_sample, he[pulses]);
        $display("txn %0d held pulse=%0d cycle=%0d out=%h", txn_no, pulses, c, out_sample);
        txn_no++;
        pulses++;
      end
    end
    fir_go = 1'b0;
    check("held_count", pulses, 3);
    @(posedge clk);
    #1;
    check("held_idle", busy, 0);

    // Reset in cycle 4 of a run aborts it without a done pulse.
    x_in = 16'sh3000;
    a_in = 16'sh2222;
    weight_adjust = 16'sh4000;
    adapt_en = 1'b1;
    fir_go = 1'b1;
    @(posedge clk);
    #1 fir_go = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      if (out_valid || done) seen++;
    end
    check("abort_pulse", seen, 0);
    check("abort_busy", busy, 0);
    $display("txn %0d abort pulses=%0d", txn_no, seen);
    txn_no++;
    run_txn("req39", shortint'($urandom), 16'sh0000, shortint'($urandom), 1'b0, 1'b0, obs);
    check("req39_val", obs, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
